elastic_pipe_reg: RTL and testbench
===================================

// Module: elastic_pipe_reg
// PURPOSE
//   Parametrised inter-stage pipeline register, the successor to the fixed per-stage
//   registers (ID/EX, EX/MEM, MEM/WB). Carries STAGES back-to-back slots of
//   {control, data} with a valid/ready handshake, per-slot stall back-pressure and flush.
//   Control fields become bubbles (zero) on flush or empty advance; data fields are don't-care.
// PARAMETERS
//   CTRL_W   4    width of control field (RegWr, MemToReg, ...); zeroed on bubble/flush/reset
//   DATA_W   32   width of data payload (ALU result, mem data, PC+4, ...)
//   STAGES   1    number of register slots in series; legal range 1..8
//   OCC_W    4    width of occupancy output; must satisfy 2**OCC_W > STAGES
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        upstream presents a valid entry
//   in_ready   out  1        slot 0 accepts this cycle
//   in_ctrl    in   CTRL_W   upstream control field
//   in_data    in   DATA_W   upstream data payload
//   flush      in   1        kill all held entries (branch/exception)
//   out_valid  out  1        last slot holds a valid entry
//   out_ready  in   1        downstream accepts this cycle
//   out_ctrl   out  CTRL_W   control of last slot (0 when out_valid=0)
//   out_data   out  DATA_W   data of last slot
//   occupancy  out  OCC_W    number of valid slots
// BEHAVIOUR
//   - State per slot i (0=input side, STAGES-1=output side): v[i], ctrl[i], data[i].
//   - Reset (async, reset=1): all v=0, ctrl=0, data=0 immediately; in_ready=0 while
//     reset=1; out_valid=0, out_ctrl=0, out_data=0, occupancy=0. First accept is on the
//     first rising edge after reset deasserts.
//   - Ready chain (combinational): rdy[STAGES]=out_ready; rdy[i]=~v[i] | rdy[i+1];
//     in_ready = rdy[0] & ~flush & ~reset.
//   - Advance on posedge when rdy[i]=1 and flush=0: slot i loads slot i-1 (slot 0 loads
//     input with valid = in_valid & in_ready). Source valid=1 -> copy v/ctrl/data;
//     source valid=0 -> v=0, ctrl=0, data unchanged.
//   - Stall: rdy[i]=0 -> slot i holds v/ctrl/data unchanged.
//   - Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
//   - Full throughput: with out_ready=1 one entry/cycle; latency in_valid -> out_valid
//     exactly STAGES cycles.
//   - Bubble compression: an empty slot accepts even when downstream stalls, so
//     holes close up under back-pressure.
//   - Full: all v=1 and out_ready=0 -> in_ready=0. Simultaneous pop+push when full is
//     allowed (rdy propagates), occupancy unchanged.
//   - Flush (sync, priority over advance): next edge all v=0, ctrl=0, data held;
//     in_ready=0 that cycle so input is not accepted. out_valid may be 1 during the
//     flush cycle; downstream must qualify with flush.
//   - out_ctrl = ctrl[STAGES-1] (zero by construction when invalid); out_data is
//     data[STAGES-1] unqualified.
//   - occupancy = popcount(v), combinational from registers; range 0..STAGES.
//   - Reset mid-stream: all entries lost, no partial transfer; flush+reset same
//     cycle == reset.
// TESTING
//   1 STAGES=1: reset=1 then 0; in_valid=1, data=0x11..0x15 back-to-back, out_ready=1
//     -> out_data 0x11..0x15 on consecutive cycles, 1-cycle latency, occupancy<=1.
//   2 STAGES=3: stream 0xA0,0xA1,0xA2, out_ready=0 from cycle 3 -> occupancy reaches 3,
//     in_ready=0; release out_ready -> 0xA0,0xA1,0xA2 in order, none lost/duplicated.
//   3 STAGES=3: entries at slots 0 and 2 only, out_ready=0 -> next edge slot1 filled,
//     occupancy stays 2, in_ready=1.
//   4 STAGES=2 full, in_ctrl=4'hF: pulse flush 1 cycle with in_valid=1 -> next cycle
//     out_valid=0, out_ctrl=0, occupancy=0, flushed-cycle input absent from output.
//   5 Assert reset asynchronously between edges with occupancy=2 -> out_valid, out_ctrl,
//     out_data, occupancy go 0 before next edge; in_ready=0 until release.
//   6 Random in_valid/out_ready, 10k cycles vs. scoreboard FIFO model -> order
//     preserved, occupancy matches model each cycle.

Source files
------------

// File: rtl/elastic_pipe_reg.sv
`default_nettype none
// =============================================================================
// Module      : elastic_pipe_reg
// Description : STAGES-deep valid/ready pipeline register with bubble
//               compression, synchronous flush and zeroed control on bubbles.
// Revision    : 1.0 - initial release
// =============================================================================
module elastic_pipe_reg #(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 32,
   parameter int STAGES = 1,
   parameter int OCC_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [OCC_W-1:0]  occupancy
);

   logic [STAGES-1:0] r_slotValid;
   logic [CTRL_W-1:0] r_slotCtrl [STAGES];
   logic [DATA_W-1:0] r_slotData [STAGES];

   logic [STAGES:0]   w_rdy;
   logic [STAGES-1:0] w_srcValid;
   logic [CTRL_W-1:0] w_srcCtrl [STAGES];
   logic [DATA_W-1:0] w_srcData [STAGES];
   logic              w_push;

   // A slot can take a new entry if it is empty or its occupant moves on,
   // which lets holes close up even while the output is stalled.
   assign w_rdy[STAGES] = out_ready;
   assign in_ready      = w_rdy[0] & ~flush & ~reset;
   assign w_push        = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_slot
         assign w_rdy[gi] = ~r_slotValid[gi] | w_rdy[gi+1];
         if (gi == 0) begin : g_head
            assign w_srcValid[gi] = w_push;
            assign w_srcCtrl[gi]  = in_ctrl;
            assign w_srcData[gi]  = in_data;
         end else begin : g_body
            assign w_srcValid[gi] = r_slotValid[gi-1];
            assign w_srcCtrl[gi]  = r_slotCtrl[gi-1];
            assign w_srcData[gi]  = r_slotData[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slotValid <= '0;
         for (int i = 0; i < STAGES; i++) begin
            r_slotCtrl[i] <= '0;
            r_slotData[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (flush) begin
               r_slotValid[i] <= 1'b0;
               r_slotCtrl[i]  <= '0;
            end else if (w_rdy[i]) begin
               r_slotValid[i] <= w_srcValid[i];
               if (w_srcValid[i]) begin
                  r_slotCtrl[i] <= w_srcCtrl[i];
                  r_slotData[i] <= w_srcData[i];
               end else begin
                  r_slotCtrl[i] <= '0;
               end
            end
         end
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < STAGES; i++) begin
         occupancy = occupancy + OCC_W'(r_slotValid[i]);
      end
   end

   assign out_valid = r_slotValid[STAGES-1];
   assign out_ctrl  = r_slotCtrl[STAGES-1];
   assign out_data  = r_slotData[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe_reg.sv
`default_nettype none
// =============================================================================
// Module      : tb_elastic_pipe_reg
// Description : Shared stimulus into 1-, 2- and 3-stage instances, each checked
//               against an entry queue that tracks the slot position of every entry.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_elastic_pipe_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic [3:0]  inCtrl;
   logic [31:0] inData;
   logic        flush;
   logic        outReady;

   logic        inReady   [3];
   logic        outValid  [3];
   logic [3:0]  outCtrl   [3];
   logic [31:0] outData   [3];
   logic [3:0]  occupancy [3];

   int checks = 0;
   int errors = 0;

   // Scoreboard: per instance, entries oldest first with their current slot.
   int          qCnt  [3];
   int          qPos  [3][8];
   logic [3:0]  qCtrl [3][8];
   logic [31:0] qData [3][8];

   always #5 clk = ~clk;

   elastic_pipe_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(1), .OCC_W(4)) u_s1 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[0]),
      .in_ctrl(inCtrl), .in_data(inData), .flush(flush), .out_valid(outValid[0]),
      .out_ready(outReady), .out_ctrl(outCtrl[0]), .out_data(outData[0]),
      .occupancy(occupancy[0]));

   elastic_pipe_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(2), .OCC_W(4)) u_s2 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[1]),
      .in_ctrl(inCtrl), .in_data(inData), .flush(flush), .out_valid(outValid[1]),
      .out_ready(outReady), .out_ctrl(outCtrl[1]), .out_data(outData[1]),
      .occupancy(occupancy[1]));

   elastic_pipe_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(3), .OCC_W(4)) u_s3 (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[2]),
      .in_ctrl(inCtrl), .in_data(inData), .flush(flush), .out_valid(outValid[2]),
      .out_ready(outReady), .out_ctrl(outCtrl[2]), .out_data(outData[2]),
      .occupancy(occupancy[2]));

   task automatic check(input string tag, input int k, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s[STAGES=%0d] t=%0t: observed %0h expected %0h",
                tag, k + 1, $time, obs, exp);
      end
   endtask

   function automatic bit expInReady(input int k);
      return ((qCnt[k] < k + 1) || outReady) && !flush && !reset;
   endfunction

   // Check outputs of the current cycle, then advance the model across the edge.
   task automatic step();
      #1;
      if (reset) begin
         for (int k = 0; k < 3; k++) qCnt[k] = 0;
      end
      for (int k = 0; k < 3; k++) begin
         bit expOv;
         expOv = (qCnt[k] > 0) && (qPos[k][0] == k);
         check("in_ready", k, 32'(inReady[k]), 32'(expInReady(k)));
         check("out_valid", k, 32'(outValid[k]), 32'(expOv));
         check("occupancy", k, 32'(occupancy[k]), 32'(qCnt[k]));
         check("out_ctrl", k, 32'(outCtrl[k]), expOv ? 32'(qCtrl[k][0]) : 32'h0);
         if (expOv) check("out_data", k, outData[k], qData[k][0]);
         else if (reset) check("out_data_rst", k, outData[k], 32'h0);
      end
      for (int k = 0; k < 3; k++) begin
         bit doPush;
         bit mv [8];
         doPush = inValid && expInReady(k);
         if (reset || flush) begin
            qCnt[k] = 0;
         end else begin
            for (int j = 0; j < qCnt[k]; j++) begin
               if (qPos[k][j] == k) mv[j] = outReady;
               else if (j == 0) mv[j] = 1'b1;
               else mv[j] = (qPos[k][j] + 1 != qPos[k][j-1]) || mv[j-1];
            end
            for (int j = 0; j < qCnt[k]; j++) if (mv[j]) qPos[k][j]++;
            if (qCnt[k] > 0 && qPos[k][0] == k + 1) begin
               for (int j = 1; j < qCnt[k]; j++) begin
                  qPos[k][j-1]  = qPos[k][j];
                  qCtrl[k][j-1] = qCtrl[k][j];
                  qData[k][j-1] = qData[k][j];
               end
               qCnt[k]--;
            end
            if (doPush) begin
               qPos[k][qCnt[k]]  = 0;
               qCtrl[k][qCnt[k]] = inCtrl;
               qData[k][qCnt[k]] = inData;
               qCnt[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d,
                        input logic ordy);
      inValid  = v;
      inCtrl   = c;
      inData   = d;
      outReady = ordy;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) qCnt[k] = 0;
      reset = 1'b1; flush = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 1'b0);
      @(negedge clk);
      step();
      step();
      reset = 1'b0;

      // Back-to-back stream at full throughput
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 4'(i + 1), 32'h11 + 32'(i), 1'b1);
         step();
      end
      drive(1'b0, 4'h0, 32'h0, 1'b1);
      repeat (4) step();

      // Fill under back-pressure, then drain in order
      drive(1'b1, 4'h2, 32'hA0, 1'b1); step();
      drive(1'b1, 4'h3, 32'hA1, 1'b1); step();
      drive(1'b1, 4'h4, 32'hA2, 1'b0); step();
      drive(1'b1, 4'h5, 32'hA3, 1'b0);
      repeat (3) step();
      drive(1'b0, 4'h0, 32'h0, 1'b1);
      repeat (5) step();

      // Hole between two entries closes while output is stalled
      drive(1'b1, 4'h6, 32'hB0, 1'b0); step();
      drive(1'b0, 4'h0, 32'h0, 1'b0);  step();
      drive(1'b1, 4'h7, 32'hB1, 1'b0); step();
      drive(1'b0, 4'h0, 32'h0, 1'b0);  repeat (2) step();
      drive(1'b0, 4'h0, 32'h0, 1'b1);  repeat (4) step();

      // Flush a full pipe while input is offered
      drive(1'b1, 4'hF, 32'hC0, 1'b0); step();
      drive(1'b1, 4'hF, 32'hC1, 1'b0); step();
      flush = 1'b1;
      drive(1'b1, 4'hF, 32'hDEAD, 1'b0); step();
      flush = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 1'b1); repeat (4) step();

      // Asynchronous reset with entries in flight
      drive(1'b1, 4'h9, 32'hE0, 1'b0); step();
      drive(1'b1, 4'hA, 32'hE1, 1'b0); step();
      drive(1'b0, 4'h0, 32'h0, 1'b0);
      #3 reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("async_rst_out_valid", k, 32'(outValid[k]), 32'h0);
         check("async_rst_occupancy", k, 32'(occupancy[k]), 32'h0);
         check("async_rst_out_ctrl", k, 32'(outCtrl[k]), 32'h0);
         check("async_rst_out_data", k, outData[k], 32'h0);
         check("async_rst_in_ready", k, 32'(inReady[k]), 32'h0);
      end
      @(negedge clk);
      drive(1'b1, 4'h1, 32'hE2, 1'b1);
      step();
      flush = 1'b1; step();
      flush = 1'b0; reset = 1'b0;
      step();

      // Random traffic with occasional flush and reset
      for (int n = 0; n < 10000; n++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
               1'($urandom_range(0, 2) != 0));
         flush = ($urandom_range(0, 49) == 0);
         reset = ($urandom_range(0, 999) == 0);
         step();
      end
      reset = 1'b0; flush = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 1'b1);
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
